multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_if.sv | 36 +++
 rtl/multicycle_control.sv | 86 ++++++++
 tb/tb_multicycle_control.sv | 126 ++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control bus between the multicycle FSM and its datapath
//   slave  (FSM side):      opcode, mem_ready in; strobes, selects, state, illegal, instr_count out
//   master (datapath side): the reverse directions
interface multicycle_control_if #(parameter int CNT_W = 32);
    logic [6:0]       opcode;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             ior_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic             pc_source;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [3:0]       state;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    modport slave (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_write, alu_src_a, pc_source, alu_src_b, alu_op,
               state, illegal, instr_count
    );

    modport master (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_write, alu_src_a, pc_source, alu_src_b, alu_op,
               state, illegal, instr_count
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing a multicycle RISC-V style datapath
//   clk, rst (sync, active-high); bus: multicycle_control_if.slave
//   Define MCCTRL_STALL_EN to make FETCH/MEMRD/MEMWR wait on mem_ready.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.slave  bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        EXECI  = 4'd9
    } state_t;

    state_t           st;
    state_t           dec_next;
    logic             ready;
    logic             retire;
    logic [CNT_W-1:0] cnt;

`ifdef MCCTRL_STALL_EN
    assign ready = bus.mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = bus.mem_ready;
    assign ready = 1'b1;
`endif

    always_comb begin
        dec_next = (bus.opcode == 7'b0000011 || bus.opcode == 7'b0100011) ? MEMADR :
                   (bus.opcode == 7'b0110011) ? EXEC   :
                   (bus.opcode == 7'b0010011) ? EXECI  :
                   (bus.opcode == 7'b1100011) ? BRANCH : FETCH;
    end

    // A MEMWR that is still waiting for memory has not retired yet.
    assign retire = st == MEMWB || st == ALUWB || st == BRANCH || (st == MEMWR && ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            st  <= FETCH;
            cnt <= '0;
        end else begin
            case (st)
                FETCH:   st <= ready ? DECODE : FETCH;
                DECODE:  st <= dec_next;
                MEMADR:  st <= bus.opcode[5] ? MEMWR : MEMRD;
                MEMRD:   st <= ready ? MEMWB : MEMRD;
                MEMWR:   st <= ready ? FETCH : MEMWR;
                EXEC:    st <= ALUWB;
                EXECI:   st <= ALUWB;
                default: st <= FETCH;
            endcase
            cnt <= cnt + CNT_W'(retire);
        end
    end

    assign bus.state         = st;
    assign bus.instr_count   = cnt;
    assign bus.illegal       = st == DECODE && dec_next == FETCH;
    assign bus.pc_write      = st == FETCH && ready;
    assign bus.ir_write      = st == FETCH && ready;
    assign bus.mem_read      = st == FETCH || st == MEMRD;
    assign bus.ior_d         = st == MEMRD || st == MEMWR;
    assign bus.mem_write     = st == MEMWR;
    assign bus.mem_to_reg    = st == MEMWB;
    assign bus.reg_write     = st == MEMWB || st == ALUWB;
    assign bus.alu_src_a     = st == MEMADR || st == EXEC || st == EXECI || st == BRANCH;
    assign bus.pc_write_cond = st == BRANCH;
    assign bus.pc_source     = st == BRANCH;
    assign bus.alu_src_b     = st == FETCH ? 2'b01 :
                               st == DECODE ? 2'b11 :
                               (st == MEMADR || st == EXECI) ? 2'b10 : 2'b00;
    assign bus.alu_op        = st == EXEC ? 2'b10 :
                               st == EXECI ? 2'b11 :
                               st == BRANCH ? 2'b01 : 2'b00;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench for multicycle_control with a 4-bit counter
module tb_multicycle_control;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_control_if #(.CNT_W(4)) bus ();
    multicycle_control #(.CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [3:0]  s;
        logic [13:0] v;
        logic        ill;
        logic [3:0]  c;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    logic [3:0] exp_cnt = 4'd0;

    // {pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write,
    //  mem_to_reg, reg_write, alu_src_a, pc_source, alu_src_b, alu_op}
    function automatic logic [13:0] strobes(input logic [3:0] s);
        case (s)
            4'd0:    return 14'b1001010000_01_00;
            4'd1:    return 14'b0000000000_11_00;
            4'd2:    return 14'b0000000010_10_00;
            4'd3:    return 14'b0011000000_00_00;
            4'd4:    return 14'b0000001100_00_00;
            4'd5:    return 14'b0010100000_00_00;
            4'd6:    return 14'b0000000010_00_10;
            4'd7:    return 14'b0000000100_00_00;
            4'd8:    return 14'b0100000011_00_01;
            4'd9:    return 14'b0000000010_10_11;
            default: return 14'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("state", 32'(bus.state), 32'(e.s));
            chk("strobes", 32'({bus.pc_write, bus.pc_write_cond, bus.ior_d, bus.mem_read,
                                bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_write,
                                bus.alu_src_a, bus.pc_source, bus.alu_src_b, bus.alu_op}),
                32'(e.v));
            chk("illegal", 32'(bus.illegal), 32'(e.ill));
            chk("instr_count", 32'(bus.instr_count), 32'(e.c));
        end
    end

    task automatic step(input logic [3:0] s, input logic ill, input logic ret,
                        input logic mr, input logic r);
        exp_t e;
        bus.mem_ready = mr;
        rst = r;
        e.s = s;
        e.v = strobes(s);
        e.ill = ill;
        e.c = exp_cnt;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (r) exp_cnt = 4'd0;
        else if (ret) exp_cnt = exp_cnt + 4'd1;
    endtask

    task automatic run(input logic [6:0] op, input logic [19:0] seq, input int n, input logic legal);
        bus.opcode = op;
        for (int i = 0; i < n; i++)
            step(seq[4*(n-1-i) +: 4], !legal && i == 1, legal && i == n - 1, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        bus.opcode = 7'b0;
        @(posedge clk);
        #1;
        step(4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        run(7'b0110011, 20'h00167, 4, 1'b1);
        run(7'b0000011, 20'h01234, 5, 1'b1);
        run(7'b1111111, 20'h00001, 2, 1'b0);
        run(7'b0000000, 20'h00001, 2, 1'b0);
        run(7'b0100011, 20'h00125, 4, 1'b1);
        run(7'b0010011, 20'h00197, 4, 1'b1);
        bus.opcode = 7'b0000011;
        step(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(4'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(4'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        step(4'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 16; k++)
            run(7'b1100011, 20'h00018, 3, 1'b1);
`ifdef MCCTRL_STALL_EN
        bus.opcode = 7'b0100011;
        step(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(4'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(4'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++)
            step(4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        step(4'd5, 1'b0, 1'b1, 1'b1, 1'b0);
`endif
        step(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4 && q.size() > 0; k++)
            @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
